// File: rtl/stepper_step_gen.sv
// stepper_step_gen: turns move requests into timed step pulses, a direction
// line and a coil phase pattern for the pan stepper, and keeps a signed
// absolute position count for the tracking logic.
//
// Optional feature macro: HALF_STEP_EN
//   defined   -> 8-entry half-step coil sequence, 3-bit phase index
//   undefined -> 4-entry full-step coil sequence, 2-bit phase index
//
// Handshake: 'done' is a level-sensitive valid and 'ready' is the matching
// ready. A request {dir, val} transfers on a rising clock edge where
// ready=1, done=1, halt=0 and val!=0. A request with val=0 is consumed
// without effect. While ready=0, done is ignored and nothing is queued.
// halt wins over done on the same edge.
module stepper_step_gen #(
  parameter logic [15:0] STEP_PERIOD  = 16'd50000,
  parameter logic [15:0] PULSE_CYCLES = 16'd100,
  parameter logic [15:0] DIR_SETUP    = 16'd10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dir,
  input  logic [7:0]         val,
  input  logic               done,
  input  logic               halt,
  output logic               ready,
  output logic               step,
  output logic               dir_out,
  output logic [3:0]         coils,
  output logic signed [15:0] position,
  output logic [7:0]         steps_left,
  output logic [1:0]         state_dbg
);

`ifdef HALF_STEP_EN
  localparam int PW = 3;
`else
  localparam int PW = 2;
`endif
  localparam logic [PW-1:0] PH_ONE = PW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    PULSE  = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   timer;
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;
  logic [3:0]    coils_nxt;
  logic          ready_nxt;
  logic          step_nxt;
  logic          accept;
  logic          dir_change;
  logic          pulse_entry;

  // Coil pattern for a given phase index.
  function automatic logic [3:0] coil_lut(input logic [PW-1:0] p);
    logic [3:0] c;
    c = 4'b0000;
`ifdef HALF_STEP_EN
    case (p)
      3'd0:    c = 4'b0001;
      3'd1:    c = 4'b0011;
      3'd2:    c = 4'b0010;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0100;
      3'd5:    c = 4'b1100;
      3'd6:    c = 4'b1000;
      default: c = 4'b1001;
    endcase
`else
    case (p)
      2'd0:    c = 4'b0011;
      2'd1:    c = 4'b0110;
      2'd2:    c = 4'b1100;
      default: c = 4'b1001;
    endcase
`endif
    return c;
  endfunction

  assign accept     = (state == IDLE) && done && !halt && (val != 8'd0);
  assign dir_change = (dir != dir_out);
  assign state_dbg  = state;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; the timer counts cycles since SETTLE entry or since
  // the current step rise, so PULSE and GAP share one time base.
  always_comb begin
    state_nxt = state;
    if (halt) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = dir_change ? SETTLE : PULSE;
        SETTLE:  if (timer == DIR_SETUP - 16'd1) state_nxt = PULSE;
        PULSE:   if (timer == PULSE_CYCLES - 16'd1) state_nxt = GAP;
        GAP:     if (timer == STEP_PERIOD - 16'd1)
                   state_nxt = (steps_left != 8'd0) ? PULSE : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: next values of the registered outputs and phase.
  always_comb begin
    pulse_entry = (state_nxt == PULSE) && (state != PULSE);
    phase_nxt   = phase;
    if (pulse_entry) phase_nxt = dir_out ? (phase + PH_ONE) : (phase - PH_ONE);
    coils_nxt   = coil_lut(phase_nxt);
    ready_nxt   = (state_nxt == IDLE);
    step_nxt    = (state_nxt == PULSE);
  end

  // Registered outputs, so no input reaches an output combinationally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready <= 1'b1;
      step  <= 1'b0;
      coils <= coil_lut('0);
      phase <= '0;
    end else begin
      ready <= ready_nxt;
      step  <= step_nxt;
      coils <= coils_nxt;
      phase <= phase_nxt;
    end
  end

  // Datapath: timer, remaining steps, direction line and position.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer      <= 16'd0;
      steps_left <= 8'd0;
      dir_out    <= 1'b0;
      position   <= 16'sd0;
    end else begin
      if (pulse_entry || (state_nxt == IDLE) || (accept && dir_change))
        timer <= 16'd0;
      else
        timer <= timer + 16'd1;

      // A direct IDLE->PULSE accept latches val and spends one step at once.
      if (halt)
        steps_left <= 8'd0;
      else if (pulse_entry)
        steps_left <= ((state == IDLE) ? val : steps_left) - 8'd1;
      else if (accept)
        steps_left <= val;

      if (accept && dir_change) dir_out <= dir;

      if (pulse_entry)
        position <= dir_out ? (position + 16'sd1) : (position - 16'sd1);
    end
  end

endmodule

// File: tb/tb_stepper_step_gen.sv
// tb_stepper_step_gen: directed bench for stepper_step_gen. A table of moves
// with hand-computed pulse timing, coil patterns and positions, plus
// hand-written sequences for continuous-go, halt, ignored requests, val=0,
// and position wrap (on a second, fast-timed instance).
module tb_stepper_step_gen;

  localparam logic [15:0] SP = 16'd8;
  localparam logic [15:0] PC = 16'd2;
  localparam logic [15:0] DS = 16'd3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT A (test-plan timing) ----------------
  logic        dir, done, halt;
  logic [7:0]  val;
  logic        ready, step, dir_out;
  logic [3:0]  coils;
  logic [15:0] position;
  logic [7:0]  steps_left;
  logic [1:0]  state_dbg;

  stepper_step_gen #(.STEP_PERIOD(SP), .PULSE_CYCLES(PC), .DIR_SETUP(DS)) dut (
    .clock(clock), .reset(reset), .dir(dir), .val(val), .done(done), .halt(halt),
    .ready(ready), .step(step), .dir_out(dir_out), .coils(coils),
    .position(position), .steps_left(steps_left), .state_dbg(state_dbg)
  );

  // ---------------- DUT B (fastest timing, for position wrap) ----------------
  logic        dir_b, done_b, halt_b;
  logic [7:0]  val_b;
  logic        ready_b, step_b, dir_out_b;
  logic [3:0]  coils_b;
  logic [15:0] position_b;
  logic [7:0]  steps_left_b;
  logic [1:0]  state_dbg_b;

  stepper_step_gen #(.STEP_PERIOD(16'd2), .PULSE_CYCLES(16'd1), .DIR_SETUP(16'd1)) dut_b (
    .clock(clock), .reset(reset), .dir(dir_b), .val(val_b), .done(done_b), .halt(halt_b),
    .ready(ready_b), .step(step_b), .dir_out(dir_out_b), .coils(coils_b),
    .position(position_b), .steps_left(steps_left_b), .state_dbg(state_dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- move driver / observer for DUT A ----------------
  int         rise_cyc[$];
  logic [3:0] rise_coil[$];
  logic [7:0] rise_left[$];
  int         high_len[$];
  int         acc_cyc;
  int         rdy_cyc;

  // Present one request for a single edge, then watch until ready returns.
  // acc_cyc is the accept edge; a rise observed right after that edge has
  // offset 0 (step was registered on the accept edge itself).
  task automatic run_move(input logic d, input logic [7:0] v);
    int   hl;
    logic prev;
    rise_cyc.delete(); rise_coil.delete(); rise_left.delete(); high_len.delete();
    @(negedge clock);
    dir = d; val = v; done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    acc_cyc = cyc;
    prev = 1'b0; hl = 0; rdy_cyc = -1;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) @(negedge clock);
      if (step && !prev) begin
        rise_cyc.push_back(cyc);
        rise_coil.push_back(coils);
        rise_left.push_back(steps_left);
      end
      if (step) hl++;
      else if (prev) begin
        high_len.push_back(hl);
        hl = 0;
      end
      prev = step;
      if (ready) begin
        rdy_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_ready(input int budget, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- move table ----------------
  typedef struct {
    logic            d;
    logic [7:0]      v;
    int              lat;   // accept edge -> first rise edge
    logic [0:2][3:0] c;     // coils at each rise
    logic [15:0]     pos;   // position after the move
  } move_t;

  move_t tbl [5];

  // ---------------- main test ----------------
  initial begin : main_test
    logic        ok;
    logic [15:0] exp_pos;
    int          n_rise, n_rdy_hi, last_rise;
    logic        prev;

    dir = 1'b0; val = 8'd0; done = 1'b0; halt = 1'b0;

`ifdef HALF_STEP_EN
    tbl[0] = '{d: 1'b0, v: 8'd2, lat: 0,  c: {4'b1001, 4'b1000, 4'b0000}, pos: 16'hFFFE};
    tbl[1] = '{d: 1'b1, v: 8'd3, lat: DS, c: {4'b1001, 4'b0001, 4'b0011}, pos: 16'h0001};
    tbl[2] = '{d: 1'b1, v: 8'd2, lat: 0,  c: {4'b0010, 4'b0110, 4'b0000}, pos: 16'h0003};
    tbl[3] = '{d: 1'b0, v: 8'd1, lat: DS, c: {4'b0010, 4'b0000, 4'b0000}, pos: 16'h0002};
    tbl[4] = '{d: 1'b0, v: 8'd3, lat: 0,  c: {4'b0011, 4'b0001, 4'b1001}, pos: 16'hFFFF};
`else
    tbl[0] = '{d: 1'b1, v: 8'd3, lat: DS, c: {4'b0110, 4'b1100, 4'b1001}, pos: 16'h0003};
    tbl[1] = '{d: 1'b0, v: 8'd2, lat: DS, c: {4'b1100, 4'b0110, 4'b0000}, pos: 16'h0001};
    tbl[2] = '{d: 1'b0, v: 8'd1, lat: 0,  c: {4'b0011, 4'b0000, 4'b0000}, pos: 16'h0000};
    tbl[3] = '{d: 1'b0, v: 8'd2, lat: 0,  c: {4'b1001, 4'b1100, 4'b0000}, pos: 16'hFFFE};
    tbl[4] = '{d: 1'b1, v: 8'd3, lat: DS, c: {4'b1001, 4'b0011, 4'b0110}, pos: 16'h0001};
`endif

    // Reset state, checked while reset is held and after release.
    repeat (3) @(negedge clock);
    check("rst_ready", ready, 1'b1);
    check("rst_step", step, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_dir_out", dir_out, 1'b0);
`ifdef HALF_STEP_EN
    check("rst_coils", coils, 4'b0001);
`else
    check("rst_coils", coils, 4'b0011);
`endif
    check("rst_position", position, 16'h0000);
    check("rst_steps_left", steps_left, 8'd0);
    check("rst_state", state_dbg, 2'd0);
    check("rst_ready_after", ready, 1'b1);

    // Table-driven moves.
    for (int i = 0; i < 5; i++) begin
      run_move(tbl[i].d, tbl[i].v);
      check($sformatf("m%0d_rises", i), rise_cyc.size(), tbl[i].v);
      if (rise_cyc.size() > 0) begin
        check($sformatf("m%0d_first_rise", i), rise_cyc[0] - acc_cyc, tbl[i].lat);
        check($sformatf("m%0d_ready_back", i), rdy_cyc - rise_cyc[0], tbl[i].v * SP);
      end
      for (int j = 0; j < rise_cyc.size() && j < 3; j++) begin
        check($sformatf("m%0d_coils%0d", i, j), rise_coil[j], tbl[i].c[j]);
        check($sformatf("m%0d_left%0d", i, j), rise_left[j], tbl[i].v - 8'd1 - 8'(j));
        if (j > 0)
          check($sformatf("m%0d_period%0d", i, j), rise_cyc[j] - rise_cyc[j-1], SP);
      end
      for (int j = 0; j < high_len.size(); j++)
        check($sformatf("m%0d_high%0d", i, j), high_len[j], PC);
      check($sformatf("m%0d_position", i), position, tbl[i].pos);
      check($sformatf("m%0d_dir_out", i), dir_out, tbl[i].d);
      check($sformatf("m%0d_left_end", i), steps_left, 8'd0);
      check($sformatf("m%0d_step_end", i), step, 1'b0);
    end
    exp_pos = tbl[4].pos;

    // Continuous-go: done held for 40 edges with val=1 -> rises 9 apart.
    @(negedge clock);
    dir = 1'b1; val = 8'd1; done = 1'b1;
    n_rise = 0; n_rdy_hi = 0; last_rise = -1; prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (step && !prev) begin
        if (last_rise >= 0) check($sformatf("cont_period%0d", n_rise), cyc - last_rise, SP + 1);
        last_rise = cyc;
        n_rise++;
      end
      if (ready) n_rdy_hi++;
      prev = step;
    end
    done = 1'b0;
    check("cont_rises", n_rise, 5);
    check("cont_ready_pulses", n_rdy_hi, 4);
    wait_ready(40, ok);
    check("cont_ready_timeout", ok, 1'b1);
    exp_pos = exp_pos + 16'd5;
    check("cont_position", position, exp_pos);

    // Halt during the second step of a 5-step move.
    @(negedge clock);
    dir = 1'b1; val = 8'd5; done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    n_rise = 0; prev = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clock);
      if (step && !prev) n_rise++;
      prev = step;
      if (n_rise == 2) break;
    end
    check("halt_reached_2nd", n_rise, 2);
    check("halt_left_before", steps_left, 8'd3);
    halt = 1'b1;
    @(negedge clock);
    halt = 1'b0;
    check("halt_step", step, 1'b0);
    check("halt_ready", ready, 1'b1);
    check("halt_left", steps_left, 8'd0);
    check("halt_state", state_dbg, 2'd0);
    exp_pos = exp_pos + 16'd2;
    check("halt_position", position, exp_pos);
    check("halt_dir_out", dir_out, 1'b1);

    // A request while busy is ignored, not queued.
    @(negedge clock);
    dir = 1'b1; val = 8'd2; done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    n_rise = 0; prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clock);
      if (k == 3) begin dir = 1'b0; val = 8'd7; done = 1'b1; end
      if (k == 7) done = 1'b0;
      if (step && !prev) n_rise++;
      prev = step;
    end
    check("busy_rises", n_rise, 2);
    check("busy_ready", ready, 1'b1);
    exp_pos = exp_pos + 16'd2;
    check("busy_position", position, exp_pos);
    check("busy_dir_out", dir_out, 1'b1);

    // val=0 with done: consumed, nothing happens.
    dir = 1'b0; val = 8'd0; done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("zero_ready%0d", k), ready, 1'b1);
      check($sformatf("zero_step%0d", k), step, 1'b0);
    end
    done = 1'b0;
    check("zero_position", position, exp_pos);
    check("zero_dir_out", dir_out, 1'b1);

    // halt beats done on the same edge.
    dir = 1'b1; val = 8'd3; done = 1'b1; halt = 1'b1;
    @(negedge clock);
    done = 1'b0; halt = 1'b0;
    check("hvd_ready", ready, 1'b1);
    check("hvd_left", steps_left, 8'd0);
    check("hvd_state", state_dbg, 2'd0);
    n_rise = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (step) n_rise++;
    end
    check("hvd_no_step", n_rise, 0);
    check("hvd_position", position, exp_pos);

    // Wait for the wrap run on the second instance.
    ok = 1'b0;
    for (int k = 0; k < 80000; k++) begin
      if (b_finished) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("wrap_finished", ok, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- position wrap on DUT B ----------------
  logic b_finished = 1'b0;

  // 128 moves of 255 plus one of 127 reach 0x7FFF; then +1 and -1 cross the
  // two's-complement boundary in both directions.
  initial begin : wrap_run
    logic ok_b;
    dir_b = 1'b0; val_b = 8'd0; done_b = 1'b0; halt_b = 1'b0;
    @(posedge reset);
    repeat (3) @(negedge clock);
    for (int m = 0; m < 131; m++) begin
      @(negedge clock);
      dir_b  = (m < 130);
      val_b  = (m < 128) ? 8'd255 : ((m == 128) ? 8'd127 : 8'd1);
      done_b = 1'b1;
      @(negedge clock);
      done_b = 1'b0;
      ok_b = 1'b0;
      for (int k = 0; k < 1000; k++) begin
        if (ready_b) begin
          ok_b = 1'b1;
          break;
        end
        @(negedge clock);
      end
      if (!ok_b) begin
        check("wrap_ready_timeout", ok_b, 1'b1);
        break;
      end
      if (m == 128) check("wrap_pos_7fff", position_b, 16'h7FFF);
      if (m == 129) check("wrap_pos_8000", position_b, 16'h8000);
      if (m == 130) check("wrap_pos_back_7fff", position_b, 16'h7FFF);
    end
    b_finished = 1'b1;
  end

endmodule
